// File: rtl/down_count_timer.sv
// Loadable down counter / countdown timer with a valid/ready load handshake and a done pulse.
// Define DOWN_COUNT_TIMER_AUTO_RELOAD_EN for periodic mode (reload on the enabled cycle after 0).
module down_count_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load_valid,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_load_ready,
    input  logic             i_en,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [WIDTH-1:0] CountZero = '0;
    localparam logic [WIDTH-1:0] CountOne  = WIDTH'(1);

    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_count, w_count_next;
    logic             r_done, w_done_next;
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload, w_reload_next;
`endif

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_done_next  = 1'b0;
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
        w_reload_next = r_reload;
`endif
        if (i_abort) begin
            w_state_next = StIdle;
            w_count_next = CountZero;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_load_valid) begin
                        w_count_next = i_load_value;
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
                        w_reload_next = i_load_value;
`endif
                        if (i_load_value != CountZero) begin
                            w_state_next = StRun;
                        end else begin
                            w_done_next = 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (i_en) begin
                        if (r_count > CountOne) begin
                            w_count_next = r_count - CountOne;
                        end else if (r_count == CountOne) begin
                            w_count_next = CountZero;
                            w_done_next  = 1'b1;
`ifndef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
                            w_state_next = StIdle;
`endif
                        end else begin
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
                            w_count_next = r_reload;
`else
                            // Zero in RUN cannot occur in one-shot mode; fall back to IDLE.
                            w_state_next = StIdle;
`endif
                        end
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_count <= CountZero;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_done  <= w_done_next;
        end
    end

`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reload <= CountZero;
        end else begin
            r_reload <= w_reload_next;
        end
    end
`endif

    assign o_count      = r_count;
    assign o_done       = r_done;
    assign o_busy       = (r_state == StRun);
    assign o_load_ready = (r_state == StIdle);

endmodule

// File: doc/down_count_timer.md
Name: down_count_timer

Overview:
- Loadable N-bit down counter and countdown timer; the counterpart to the team's free-running up counters.
- Accepts a start value through a valid/ready load handshake, decrements on each enabled cycle, and pulses done when the count reaches zero.
- Used as a programmable delay or timeout generator next to the existing counter blocks.

Parameters:
WIDTH, 3, counter and load value width in bits (legal range 2..32)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset
load_valid  input  1  load request
load_value  input  WIDTH  start value, sampled when load_valid && load_ready
load_ready  output  1  block can accept a load
en  input  1  count enable; low pauses the count in RUN
abort  input  1  synchronous cancel, returns to IDLE
count  output  WIDTH  current counter value (registered)
busy  output  1  high while in RUN
done  output  1  one-cycle pulse on expiry (registered)

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, count=0, reload register=0.
  - busy=0, done=0, load_ready=1.
- States:
  - IDLE: load_ready=1, busy=0.
  - RUN: load_ready=0, busy=1.
- Per-edge priority: abort > load > decrement. done defaults to 0 every cycle unless set below.
- abort=1 (any state): next state IDLE, count<=0, done stays 0. A load presented in the same cycle is dropped.
- IDLE with load_valid=1 (handshake completes):
  - count<=load_value and reload register<=load_value.
  - load_value!=0: next state RUN.
  - load_value==0: stay IDLE and assert done for one cycle.
- IDLE with load_valid=0: count holds.
- RUN, en=0: count holds, no done.
- RUN, en=1, count>1: count<=count-1.
- RUN, en=1, count==1:
  - count<=0 and done<=1, so done is high in the same cycle count first reads 0.
  - Next state IDLE in base mode.
- Latency:
  - Load accepted at edge k with en held high: count=V after edge k, count=0 and done=1 after edge k+V.
  - Each en=0 cycle adds one cycle of delay.
- No wrap-around: count never decrements below 0 and never wraps to 2^WIDTH-1.
- Loads during RUN are not accepted because load_ready=0. The load_value max (2^WIDTH-1) is legal.
- Asserting rst mid-count forces the reset values immediately. No done is produced for the cancelled count.
- count, busy, done and load_ready are all driven from registers or state decode only. No combinational path from inputs to outputs.

Optional Feature:
Macro: DOWN_COUNT_TIMER_AUTO_RELOAD_EN
- Defined: periodic mode.
  - At the 1->0 transition done pulses as normal, but the block stays in RUN.
  - On the next enabled cycle with count==0: count<=reload register.
  - Period is therefore V+1 enabled cycles, and done pulses once per period.
  - Only abort or rst leaves RUN. load_ready stays 0 throughout RUN.
  - Load of 0 still behaves as in base mode: done pulse, stay IDLE.
- Undefined: base one-shot behaviour as above. The reload register may be optimised away.

Test Plan:
- Reset, then load_value=5 with en=1 held -> count 5,4,3,2,1,0 on successive cycles; done=1 only in the count=0 cycle; busy falls with it; load_ready=1 after.
- Load 4, en toggled 1,0,1,0,... -> count decrements only on en=1 cycles; done arrives 8 cycles after load; no early done.
- Load 0 -> state stays IDLE, single done pulse next cycle, busy never high.
- Load 7 (WIDTH=3 max), abort asserted when count=3 together with load_valid=1 -> count=0, IDLE, done never asserted, the coincident load ignored.
- load_valid held high during RUN with load_value=2 -> load_ready=0, count unaffected; the load is accepted on the first cycle back in IDLE.
- With DOWN_COUNT_TIMER_AUTO_RELOAD_EN, load 3, en=1 -> count 3,2,1,0,3,2,1,0,...; done every 4 cycles; rst low mid-period -> count=0, busy=0, load_ready=1 immediately.
